// File: rtl/ntt_butterfly_post_if.sv
// Bus bundle for the Kyber NTT butterfly post-stage: r[j]/t operands in, sum/difference out.
// Valid-only stream: in_valid qualifies a_in, t_in arrives FQMUL_LAT cycles later, out_valid qualifies results; there is no ready.
interface ntt_butterfly_post_if #(
    parameter int CNT_W = 7
);
    logic               in_valid;
    logic signed [15:0] a_in;
    logic signed [15:0] t_in;
    logic               out_valid;
    logic signed [15:0] a_out;
    logic signed [15:0] b_out;
    logic [CNT_W-1:0]   pair_cnt;
    logic               layer_done;

    modport master (
        output in_valid, a_in, t_in,
        input  out_valid, a_out, b_out, pair_cnt, layer_done
    );

    modport slave (
        input  in_valid, a_in, t_in,
        output out_valid, a_out, b_out, pair_cnt, layer_done
    );
endinterface

// File: rtl/ntt_butterfly_post.sv
// Cooley-Tukey butterfly completion: r[j] +/- fqmul(zeta, r[j+len]) with a per-layer pair counter.
// Optional BFLY_BARRETT_EN adds a Barrett-reduction register stage after the sum/difference.
module ntt_butterfly_post #(
    parameter int FQMUL_LAT      = 2,
    parameter int BFLY_PER_LAYER = 128,
    parameter int CNT_W          = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    ntt_butterfly_post_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BFLY_PER_LAYER - 1);

    logic [FQMUL_LAT-1:0] v_dly;
    logic signed [15:0]   a_dly [FQMUL_LAT];

    // r[j] rides alongside the fqmul pipeline so it meets its t at the last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_dly <= '0;
            for (int i = 0; i < FQMUL_LAT; i++) a_dly[i] <= '0;
        end else begin
            v_dly[0] <= bus.in_valid && !clr;
            a_dly[0] <= bus.a_in;
            for (int i = 1; i < FQMUL_LAT; i++) begin
                v_dly[i] <= v_dly[i-1] && !clr;
                a_dly[i] <= a_dly[i-1];
            end
        end
    end

    logic               al_v;
    logic signed [15:0] sum;
    logic signed [15:0] diff;

    assign al_v = v_dly[FQMUL_LAT-1];
    assign sum  = a_dly[FQMUL_LAT-1] + bus.t_in;
    assign diff = a_dly[FQMUL_LAT-1] - bus.t_in;

    logic               fin_v;
    logic signed [15:0] fin_a;
    logic signed [15:0] fin_b;

`ifdef BFLY_BARRETT_EN
    function automatic logic signed [15:0] barrett(input logic signed [15:0] x);
        logic signed [31:0] xe;
        logic signed [31:0] q;
        xe = 32'(x);
        q  = (xe * 32'sd20159 + 32'sd33554432) >>> 26;
        return 16'(xe - q * 32'sd3329);
    endfunction

    logic               raw_v;
    logic signed [15:0] raw_a;
    logic signed [15:0] raw_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_v <= 1'b0;
            raw_a <= '0;
            raw_b <= '0;
        end else begin
            raw_v <= al_v && !clr;
            if (al_v && !clr) begin
                raw_a <= sum;
                raw_b <= diff;
            end
        end
    end

    assign fin_v = raw_v;
    assign fin_a = barrett(raw_a);
    assign fin_b = barrett(raw_b);
`else
    assign fin_v = al_v;
    assign fin_a = sum;
    assign fin_b = diff;
`endif

    logic               out_valid_r;
    logic signed [15:0] a_r;
    logic signed [15:0] b_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               done_r;

    // Data registers hold across bubbles and clr; only valid/count state is flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            cnt_r       <= '0;
            done_r      <= 1'b0;
        end else if (clr) begin
            out_valid_r <= 1'b0;
            cnt_r       <= '0;
            done_r      <= 1'b0;
        end else begin
            out_valid_r <= fin_v;
            done_r      <= fin_v && (cnt_r == CNT_LAST);
            if (fin_v) begin
                a_r   <= fin_a;
                b_r   <= fin_b;
                cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.a_out      = a_r;
    assign bus.b_out      = b_r;
    assign bus.pair_cnt   = cnt_r;
    assign bus.layer_done = done_r;
endmodule

// File: tb/tb_ntt_butterfly_post.sv
// Scoreboard bench for ntt_butterfly_post: driver pushes expected results, a negedge monitor pops and compares.
module tb_ntt_butterfly_post;
    localparam int LAT   = 2;
    localparam int NBF   = 128;
    localparam int CNT_W = 7;
`ifdef BFLY_BARRETT_EN
    localparam int OUT_LAT = LAT + 2;
`else
    localparam int OUT_LAT = LAT + 1;
`endif

    typedef struct packed {
        logic [31:0]      cyc;
        logic [15:0]      a;
        logic [15:0]      b;
        logic [CNT_W-1:0] cnt;
        logic             done;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr   = 1'b0;
    int   cyc   = 0;

    ntt_butterfly_post_if #(.CNT_W(CNT_W)) bus ();

    ntt_butterfly_post #(
        .FQMUL_LAT     (LAT),
        .BFLY_PER_LAYER(NBF),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .clr  (clr),
        .bus  (bus.slave)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] exp_q[$];
    int            n_cmp    = 0;
    int            n_fail   = 0;
    int            push_cnt = 0;
    logic [15:0]   t_d1     = '0;
    logic [15:0]   t_d2     = '0;
    logic [15:0]   last_a   = '0;
    logic [15:0]   last_b   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] red(input logic [15:0] x);
`ifdef BFLY_BARRETT_EN
        int xs;
        int q;
        xs = int'($signed(x));
        q  = (xs * 20159 + 33554432) >>> 26;
        return 16'(xs - q * 3329);
`else
        return x;
`endif
    endfunction

    // One cycle of stimulus; t is replayed LAT cycles later to meet its own a.
    task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] t,
                         input logic [15:0] ea, input logic [15:0] eb, input bit c);
        exp_t e;
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
            push_cnt = 0;
            chk("clr_pair_cnt", 32'(bus.pair_cnt), 32'd0);
            chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        end
        clr          = c;
        bus.in_valid = v;
        bus.a_in     = a;
        bus.t_in     = t_d2;
        t_d2         = t_d1;
        t_d1         = t;
        if (v && !c) begin
            push_cnt = (push_cnt + 1) % NBF;
            e.cyc    = 32'(cyc);
            e.a      = red(ea);
            e.b      = red(eb);
            e.cnt    = push_cnt[CNT_W-1:0];
            e.done   = (push_cnt == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_a_out"}, {16'h0, bus.a_out}, 32'd0);
        chk({tag, "_b_out"}, {16'h0, bus.b_out}, 32'd0);
        chk({tag, "_pair_cnt"}, 32'(bus.pair_cnt), 32'd0);
        chk({tag, "_layer_done"}, 32'(bus.layer_done), 32'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        reset_checks("midrst");
        exp_q.delete();
        push_cnt = 0;
        last_a   = '0;
        last_b   = '0;
        #20;
        rst_n = 1'b1;
    endtask

    // monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: actual out_valid=1 required=0 (a_out=%0h)", bus.a_out);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    chk("a_out", {16'h0, bus.a_out}, {16'h0, e.a});
                    chk("b_out", {16'h0, bus.b_out}, {16'h0, e.b});
                    chk("pair_cnt", 32'(bus.pair_cnt), 32'(e.cnt));
                    chk("layer_done", 32'(bus.layer_done), 32'(e.done));
                    chk("latency", 32'(cyc) - e.cyc, 32'(OUT_LAT));
                end
                last_a = bus.a_out;
                last_b = bus.b_out;
            end else begin
                chk("idle_layer_done", 32'(bus.layer_done), 32'd0);
                chk("hold_a_out", {16'h0, bus.a_out}, {16'h0, last_a});
                chk("hold_b_out", {16'h0, bus.b_out}, {16'h0, last_b});
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.t_in     = '0;
        #1 rst_n = 1'b0;
        #2 reset_checks("reset");
        #20 rst_n = 1'b1;

        // single pair
        drive(1'b1, 16'd100, 16'd50, 16'd150, 16'd50, 1'b0);
        idle(5);

        // two's complement wrap corners
        drive(1'b1, 16'h7fff, 16'h0001, 16'h8000, 16'h7ffe, 1'b0);
        drive(1'b1, 16'hffff, 16'h0000, 16'hffff, 16'hffff, 1'b0);
        drive(1'b1, 16'h8000, 16'h0001, 16'h8001, 16'h7fff, 1'b0);
`ifdef BFLY_BARRETT_EN
        drive(1'b1, 16'd3329, 16'd3329, 16'd6658, 16'd0, 1'b0);
`endif
        idle(5);

        // flush counter, then a full layer plus one
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i <= NBF; i++)
            drive(1'b1, 16'(i * 7 - 400), 16'(i), 16'(i * 8 - 400), 16'(i * 6 - 400), 1'b0);
        idle(5);

        // gapped stream 1,0,1,1,0,1
        drive(1'b1, 16'd10, 16'd5, 16'd15, 16'd5, 1'b0);
        idle(1);
        drive(1'b1, -16'sd20, 16'd7, -16'sd13, -16'sd27, 1'b0);
        drive(1'b1, 16'd300, -16'sd300, 16'd0, 16'd600, 1'b0);
        idle(1);
        drive(1'b1, 16'd1234, -16'sd4321, -16'sd3087, 16'd5555, 1'b0);
        idle(5);

        // clr one cycle after two inputs: both dropped
        drive(1'b1, 16'd1000, 16'd1, 16'd1001, 16'd999, 1'b0);
        drive(1'b1, 16'd2000, 16'd2, 16'd2002, 16'd1998, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        idle(6);
        drive(1'b1, 16'd5, 16'd5, 16'd10, 16'd0, 1'b0);
        idle(5);

        // async reset mid-layer with results in flight
        drive(1'b1, 16'd11, 16'd1, 16'd12, 16'd10, 1'b0);
        drive(1'b1, 16'd22, 16'd2, 16'd24, 16'd20, 1'b0);
        drive(1'b1, 16'd33, 16'd3, 16'd36, 16'd30, 1'b0);
        mid_reset();
        idle(6);
        drive(1'b1, 16'd7, 16'd3, 16'd10, 16'd4, 1'b0);
        idle(6);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
